// File: rtl/sdspi_arbiter.sv
// Two-port lockable round-robin arbiter in front of the SD SPI controller's APB register port.
// Ownership is held across in-flight transfers and controller sector activity; stalled transfers are aborted by a watchdog.
module sdspi_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req0,
  input  logic        req1,
  output logic        gnt0,
  output logic        gnt1,
  input  logic        psel0,
  input  logic        penable0,
  input  logic        pwrite0,
  input  logic [15:0] paddr0,
  input  logic [31:0] pwdata0,
  output logic [31:0] prdata0,
  output logic        pready0,
  output logic        pslverr0,
  input  logic        psel1,
  input  logic        penable1,
  input  logic        pwrite1,
  input  logic [15:0] paddr1,
  input  logic [31:0] pwdata1,
  output logic [31:0] prdata1,
  output logic        pready1,
  output logic        pslverr1,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [15:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr,
  input  logic        sdsbusy,
  output logic [31:0] w_arb_status
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWNED = 2'd1,
    S_XFER  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic [15:0] wd_q, wd_d;
  logic        blk_q, blk_d;
  logic [15:0] abort_cnt_q, abort_cnt_d;

  logic        own_req, own_psel, own_penable, own_pwrite;
  logic [15:0] own_paddr;
  logic [31:0] own_pwdata;
  logic        granted, in_sess, access, abort, dn_sel, resp_ok;
  logic        rsp_rdy, rsp_err;
  logic [31:0] rsp_data;

  always_comb begin
    own_req     = owner_q ? req1     : req0;
    own_psel    = owner_q ? psel1    : psel0;
    own_penable = owner_q ? penable1 : penable0;
    own_pwrite  = owner_q ? pwrite1  : pwrite0;
    own_paddr   = owner_q ? paddr1   : paddr0;
    own_pwdata  = owner_q ? pwdata1  : pwdata0;

    granted = (state_q != S_IDLE);
    in_sess = (state_q == S_OWNED) || (state_q == S_XFER);
    // blk_q suppresses only the aborted access phase, so a fresh setup phase passes straight through
    access  = in_sess && own_psel && own_penable && !blk_q;
    abort   = (state_q == S_XFER) && !pready && (wd_q == WD_LAST);
    dn_sel  = in_sess && own_psel && !(blk_q && own_penable) && !abort;

    psel    = dn_sel;
    penable = dn_sel && own_penable;
    pwrite  = granted && own_pwrite;
    paddr   = granted ? own_paddr  : 16'h0;
    pwdata  = granted ? own_pwdata : 32'h0;

    resp_ok  = access && pready;
    rsp_rdy  = resp_ok || abort;
    rsp_err  = (resp_ok && pslverr) || abort;
    rsp_data = resp_ok ? prdata : 32'h0;

    pready0  = rsp_rdy && !owner_q;
    pslverr0 = rsp_err && !owner_q;
    prdata0  = owner_q ? 32'h0 : rsp_data;
    pready1  = rsp_rdy && owner_q;
    pslverr1 = rsp_err && owner_q;
    prdata1  = owner_q ? rsp_data : 32'h0;

    gnt0 = granted && !owner_q;
    gnt1 = granted && owner_q;
    w_arb_status = {abort_cnt_q, 10'd0, gnt1, gnt0, owner_q, 1'b0, state_q};
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    wd_d        = wd_q;
    blk_d       = blk_q && own_penable;
    abort_cnt_d = abort_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          state_d = S_OWNED;
          owner_d = (req0 && req1) ? ~owner_q : req1;
        end
      end
      S_OWNED: begin
        // a zero-wait completion finishes here and never enters XFER
        if (access && !pready) begin
          state_d = S_XFER;
          wd_d    = 16'd0;
        end else if (!own_req) begin
          state_d = sdsbusy ? S_DRAIN : S_IDLE;
        end
      end
      S_XFER: begin
        if (pready) begin
          state_d = S_OWNED;
        end else if (abort) begin
          state_d = S_OWNED;
          blk_d   = 1'b1;
          if (abort_cnt_q != 16'hFFFF) abort_cnt_d = abort_cnt_q + 16'd1;
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end
      S_DRAIN: begin
        if (!sdsbusy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE) blk_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b1;
      wd_q        <= 16'd0;
      blk_q       <= 1'b0;
      abort_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      wd_q        <= wd_d;
      blk_q       <= blk_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

endmodule
